// File: rtl/exec_unit_if.sv
// Decode handshake bundle between control_unit (master) and exec_unit (slave).
// Latency: none, wires only.
// Backpressure: dec_ready from the slave; a transfer happens when dec_valid && dec_ready at an edge.
interface exec_unit_if;
  logic       dec_valid;
  logic       dec_ready;
  logic       register;
  logic       operation;
  logic [1:0] number;

  modport master (
    output dec_valid,
    output register,
    output operation,
    output number,
    input  dec_ready
  );

  modport slave (
    input  dec_valid,
    input  register,
    input  operation,
    input  number,
    output dec_ready
  );
endinterface

// File: rtl/exec_unit.sv
// Executes decoded LDI/ADDI on a two-entry register file, updates carry/zero, pulses retire.
// Latency: accept at edge N, registers/flags update at edge N+2, retire high the cycle after N+2.
// Backpressure: dec_ready high only in IDLE, so one instruction per 3 cycles.
// Optional build macro EXEC_SATURATE_EN: ADDI saturates at all-ones instead of wrapping.
module exec_unit #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  exec_unit_if.slave        dec,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic              carry,
  output logic              zero,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic              sel_q, sel_d;
  logic              op_q, op_d;
  logic [1:0]        num_q, num_d;
  logic [DATA_W:0]   res_q, res_d;
  logic [DATA_W-1:0] r0_q, r0_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic              ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: accept in IDLE, then EXEC and WB unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dec.dec_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath next values, decoded from the current state
  always_comb begin
    ready    = (state_q == IDLE);
    sel_d    = sel_q;
    op_d     = op_q;
    num_d    = num_q;
    res_d    = res_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    imm      = {{(DATA_W-2){1'b0}}, num_q};
    src      = sel_q ? r1_q : r0_q;
    sum      = {1'b0, src} + {1'b0, imm};
    case (state_q)
      IDLE: begin
        // fields are only sampled on the accepting edge
        if (dec.dec_valid) begin
          sel_d = dec.register;
          op_d  = dec.operation;
          num_d = dec.number;
        end
      end
      EXEC: begin
        if (op_q) begin
`ifdef EXEC_SATURATE_EN
          // clamp to all-ones; the top bit still flags that clamping happened
          res_d = sum[DATA_W] ? {1'b1, {DATA_W{1'b1}}} : sum;
`else
          res_d = sum;
`endif
        end else begin
          res_d = {1'b0, imm};
        end
      end
      WB: begin
        if (sel_q) r1_d = res_q[DATA_W-1:0];
        else       r0_d = res_q[DATA_W-1:0];
        carry_d  = res_q[DATA_W];
        zero_d   = (res_q[DATA_W-1:0] == '0);
        retire_d = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
      end
      default: ;
    endcase
  end

  // datapath and architectural state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      op_q     <= 1'b0;
      num_q    <= '0;
      res_q    <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      op_q     <= op_d;
      num_q    <= num_d;
      res_q    <= res_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dec.dec_ready = ready;
  assign r0            = r0_q;
  assign r1            = r1_q;
  assign carry         = carry_q;
  assign zero          = zero_q;
  assign retire        = retire_q;
  assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed steps plus randomized instructions against an arithmetic model.
// Latency: checks retire/writeback two edges after each accepting edge.
// Backpressure: waits (bounded) for dec_ready before presenting an instruction.
module tb_exec_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] r0, r1;
  logic       carry, zero, retire;
  logic [7:0] retire_cnt;

  exec_unit_if dec_if ();

  exec_unit #(.DATA_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec        (dec_if.slave),
    .r0         (r0),
    .r1         (r1),
    .carry      (carry),
    .zero       (zero),
    .retire     (retire),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference state: register file, flags and retire count as plain integers
  int mr[2];
  int mc, mz, mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr[0] = 0; mr[1] = 0; mc = 0; mz = 1; mcnt = 0;
  endtask

  task automatic model_apply(input int sel, input int op, input int num);
    int s, v, c;
    if (op == 0) begin
      v = num; c = 0;
    end else begin
      s = mr[sel] + num;
`ifdef EXEC_SATURATE_EN
      if (s > 15) begin v = 15; c = 1; end
      else        begin v = s;  c = 0; end
`else
      v = s % 16;
      c = (s > 15) ? 1 : 0;
`endif
    end
    mr[sel] = v;
    mc   = c;
    mz   = (v == 0) ? 1 : 0;
    mcnt = (mcnt + 1) % 256;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".r0"},    {28'd0, r0},    mr[0]);
    check({tag, ".r1"},    {28'd0, r1},    mr[1]);
    check({tag, ".carry"}, {31'd0, carry}, mc);
    check({tag, ".zero"},  {31'd0, zero},  mz);
    check({tag, ".cnt"},   {24'd0, retire_cnt}, mcnt);
  endtask

  // called at a negedge; returns at the negedge after writeback
  task automatic issue(input int sel, input int op, input int num);
    int waited = 0;
    while (dec_if.dec_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("issue.ready_wait", {31'd0, dec_if.dec_ready}, 1);
    dec_if.dec_valid = 1'b1;
    dec_if.register  = sel[0];
    dec_if.operation = op[0];
    dec_if.number    = num[1:0];
    @(posedge clk);
    #1;
    dec_if.dec_valid = 1'b0;
    dec_if.register  = 1'($urandom);
    dec_if.operation = 1'($urandom);
    dec_if.number    = 2'($urandom);
    @(negedge clk);
    check("exec.ready",  {31'd0, dec_if.dec_ready}, 0);
    check("exec.retire", {31'd0, retire}, 0);
    check("exec.r0",     {28'd0, r0}, mr[0]);
    check("exec.r1",     {28'd0, r1}, mr[1]);
    @(negedge clk);
    check("wb.ready",  {31'd0, dec_if.dec_ready}, 0);
    check("wb.retire", {31'd0, retire}, 0);
    check("wb.cnt",    {24'd0, retire_cnt}, mcnt);
    model_apply(sel, op, num);
    @(negedge clk);
    check("done.retire", {31'd0, retire}, 1);
    check("done.ready",  {31'd0, dec_if.dec_ready}, 1);
    check_state("done");
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      dec_if.dec_valid = 1'b0;
      dec_if.register  = 1'($urandom);
      dec_if.operation = 1'($urandom);
      dec_if.number    = 2'($urandom);
      @(negedge clk);
      check("idle.retire", {31'd0, retire}, 0);
      check("idle.ready",  {31'd0, dec_if.dec_ready}, 1);
      check_state("idle");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int fsel[9], fop[9], fnum[9];

    dec_if.dec_valid = 1'b0;
    dec_if.register  = 1'b0;
    dec_if.operation = 1'b0;
    dec_if.number    = 2'd0;
    model_reset();

    // reset held for two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.ready",  {31'd0, dec_if.dec_ready}, 1);
    check("rst.retire", {31'd0, retire}, 0);
    check_state("rst");

    // LDI R1, 3 with cycle-accurate retire/ready checks inside issue
    issue(1, 0, 3);
    check("ldi.r1",   {28'd0, r1}, 3);
    check("ldi.r0",   {28'd0, r0}, 0);
    check("ldi.zero", {31'd0, zero}, 0);
    @(negedge clk);
    check("ldi.retire_once", {31'd0, retire}, 0);

    // wrap / saturate sequence on R0
    issue(0, 0, 3);
    for (int k = 0; k < 4; k++) issue(0, 1, 3);
    check("seq.r0_15", {28'd0, r0}, 15);
    check("seq.carry_pre", {31'd0, carry}, 0);
    issue(0, 1, 1);
`ifdef EXEC_SATURATE_EN
    check("sat.r0",    {28'd0, r0}, 15);
    check("sat.carry", {31'd0, carry}, 1);
    check("sat.zero",  {31'd0, zero}, 0);
`else
    check("wrap.r0",    {28'd0, r0}, 0);
    check("wrap.carry", {31'd0, carry}, 1);
    check("wrap.zero",  {31'd0, zero}, 1);
`endif
    check("seq.r1_kept", {28'd0, r1}, 3);
    idle_cycles(2);

    // back-to-back: valid held high with fields changing every cycle
    cnt0 = mcnt;
    for (int i = 0; i < 9; i++) begin
      fsel[i] = int'($urandom_range(0, 1));
      fop[i]  = int'($urandom_range(0, 1));
      fnum[i] = int'($urandom_range(0, 3));
      dec_if.dec_valid = 1'b1;
      dec_if.register  = fsel[i][0];
      dec_if.operation = fop[i][0];
      dec_if.number    = fnum[i][1:0];
      check("b2b.ready", {31'd0, dec_if.dec_ready}, (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 0) model_apply(fsel[i], fop[i], fnum[i]);
      @(posedge clk);
      @(negedge clk);
    end
    dec_if.dec_valid = 1'b0;
    check("b2b.cnt3", {24'd0, retire_cnt}, (cnt0 + 3) % 256);
    check("b2b.retire", {31'd0, retire}, 1);
    check_state("b2b");
    idle_cycles(1);

    // reset while in EXEC abandons the instruction
    dec_if.dec_valid = 1'b1;
    dec_if.register  = 1'b1;
    dec_if.operation = 1'b0;
    dec_if.number    = 2'd2;
    @(posedge clk);
    #1;
    dec_if.dec_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("midrst.retire", {31'd0, retire}, 0);
    check("midrst.ready",  {31'd0, dec_if.dec_ready}, 1);
    check_state("midrst");
    idle_cycles(3);

    // randomized instructions; enough to wrap retire_cnt past 255
    for (int n = 0; n < 270; n++) begin
      issue(int'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 3)));
      if (mcnt == 0) check("cnt.wrap", {24'd0, retire_cnt}, 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Consumer side of the control unit's decode interface.
- Accepts decoded fields (register select, operation, 2-bit immediate) through a valid/ready handshake and executes them on a two-entry 4-bit register file.
- Updates carry and zero flags and pulses a retire strobe so the control unit can fetch the next instruction.
- Sits between control_unit and the processor's observable state (register outputs and flags).

Parameters:
- DATA_W, 4, register and ALU width in bits; fixed at 4 for this processor; other values are unsupported.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- dec_valid  input  1  decoded instruction present on register/operation/number.
- dec_ready  output  1  exec_unit can accept an instruction this cycle.
- register  input  1  destination/source register select: 0 = R0, 1 = R1.
- operation  input  1  0 = LDI (load immediate), 1 = ADDI (add immediate).
- number  input  2  unsigned immediate operand, zero-extended to DATA_W.
- r0  output  DATA_W  current R0 contents.
- r1  output  DATA_W  current R1 contents.
- carry  output  1  carry flag.
- zero  output  1  zero flag.
- retire  output  1  one-cycle pulse when an instruction completes writeback.
- retire_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset, synchronous: while rst is high at a clock edge, the next state is:
  - state = IDLE
  - r0 = 0, r1 = 0
  - carry = 0, zero = 1
  - retire = 0, retire_cnt = 0
  - dec_ready = 1 as soon as rst deasserts
- Reset mid-operation abandons any captured instruction with no writeback and no retire.
- State machine: IDLE, EXEC, WB.
- IDLE:
  - dec_ready = 1.
  - If dec_valid is high at the edge, capture register/operation/number into internal latches and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - dec_ready = 0.
  - Compute a DATA_W+1-bit result:
    - LDI: result = {1'b0, zero-extended number}.
    - ADDI: result = selected register + zero-extended number.
  - Register the result and go to WB.
- WB:
  - dec_ready = 0.
  - Write result[DATA_W-1:0] to the selected register.
  - carry = result[DATA_W]; this is 0 for LDI.
  - zero = (result[DATA_W-1:0] == 0).
  - Assert retire for exactly this cycle; increment retire_cnt.
  - Go to IDLE.
- Timing:
  - Handshake at edge N; register and flag outputs update at edge N+2; retire is high during the cycle after edge N+2.
  - Throughput is one instruction per 3 cycles.
- Input capture: inputs are sampled only on the accepting edge. Changes to register/operation/number while not in IDLE are ignored.
- dec_valid deasserted with no handshake: no state change and no flag change.
- Wrap-around:
  - ADDI wraps modulo 2^DATA_W and sets carry (e.g. 15 + 1 → 0, carry = 1, zero = 1).
  - retire_cnt wraps from 2^CNT_W - 1 to 0 with no flag.
- The unselected register is never modified.
- All outputs are driven directly from flops, so there is no combinational path from inputs to outputs. dec_ready is the only exception: it is decoded from the state register only.

Optional Feature:
- Macro EXEC_SATURATE_EN.
- Defined:
  - ADDI saturates at 2^DATA_W - 1 (15).
  - carry is set whenever saturation occurred.
  - zero is computed on the saturated value.
- Undefined:
  - Modulo wrap as specified above.
- LDI behaviour is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles, release → r0 = r1 = 0, carry = 0, zero = 1, retire_cnt = 0, dec_ready = 1.
- LDI R1, 3 handshake at edge N → r1 = 3, r0 unchanged, zero = 0, carry = 0 at edge N+2. Retire pulse lasts exactly 1 cycle and dec_ready is low for exactly 2 cycles.
- Wrap (non-saturate build): LDI R0, 3, then ADDI R0, 3 ×4 → r0 = 15; one further ADDI R0, 1 → r0 = 0, carry = 1, zero = 1.
- Saturate (EXEC_SATURATE_EN build): same sequence → r0 = 15, carry = 1, zero = 0.
- Back-to-back: dec_valid held high with changing fields → only the instructions present on the accepting edges (IDLE cycles) execute; retire_cnt = 3 after 9 cycles.
- Reset mid-op: assert rst while in EXEC → no writeback, no retire pulse, all outputs at reset values on the next edge.
